// File: rtl/dcache_wt.sv
// Direct-mapped, write-through, no-write-allocate data cache.
// The CPU side is a responder and the memory side an initiator on the request/waitrequest protocol.
// Read hits finish in the request cycle. Misses and writes go to memory.
module dcache_wt #(
  parameter int unsigned LINES = 64
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] cpu_addr,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic [3:0]  cpu_wr_be,
  input  logic [31:0] cpu_wr_data,
  output logic [31:0] cpu_rd_data,
  output logic        cpu_waitrequest,
  output logic [31:0] mem_addr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [3:0]  mem_wr_be,
  output logic [31:0] mem_wr_data,
  input  logic [31:0] mem_rd_data,
  input  logic        mem_waitrequest,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);
  localparam int unsigned IDX_W = $clog2(LINES);
  localparam int unsigned TAG_W = 32 - IDX_W - 2;

  typedef enum logic [2:0] {StIdle, StFill, StResp, StWrite, StWack} state_e;

  state_e           state_q, state_d;
  logic [31:0]      addr_q, wdata_q, resp_q;
  logic [3:0]       be_q;
  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q [LINES];
  logic [31:0]      data_q [LINES];
  logic [31:0]      hit_count_q, miss_count_q;

  logic [IDX_W-1:0] cpu_idx, cap_idx;
  logic [TAG_W-1:0] cpu_tag, cap_tag;
  logic             cpu_hit, cap_hit;
  logic             capture, fill_en, merge_en, hit_inc, miss_inc;

  assign cpu_idx = cpu_addr[IDX_W+1:2];
  assign cpu_tag = cpu_addr[31:IDX_W+2];
  assign cap_idx = addr_q[IDX_W+1:2];
  assign cap_tag = addr_q[31:IDX_W+2];
  assign cpu_hit = valid_q[cpu_idx] && (tag_q[cpu_idx] == cpu_tag);
  // The write hit test sees storage as it stands in the WRITE state.
  assign cap_hit = valid_q[cap_idx] && (tag_q[cap_idx] == cap_tag);

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;

  // Next-state logic and CPU-side handshake; cpu_waitrequest is forced high during reset.
  always_comb begin
    state_d         = state_q;
    cpu_waitrequest = 1'b0;
    cpu_rd_data     = '0;
    capture         = 1'b0;
    fill_en         = 1'b0;
    merge_en        = 1'b0;
    hit_inc         = 1'b0;
    miss_inc        = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cpu_wr) begin
          cpu_waitrequest = 1'b1;
          capture         = 1'b1;
          state_d         = StWrite;
        end else if (cpu_rd) begin
          if (cpu_hit) begin
            cpu_rd_data = data_q[cpu_idx];
            hit_inc     = 1'b1;
          end else begin
            cpu_waitrequest = 1'b1;
            capture         = 1'b1;
            miss_inc        = 1'b1;
            state_d         = StFill;
          end
        end
      end
      StFill: begin
        cpu_waitrequest = 1'b1;
        if (!mem_waitrequest) begin
          fill_en = 1'b1;
          state_d = StResp;
        end
      end
      StResp: begin
        cpu_rd_data = resp_q;
        state_d     = StIdle;
      end
      StWrite: begin
        cpu_waitrequest = 1'b1;
        if (!mem_waitrequest) begin
          merge_en = cap_hit;
          state_d  = StWack;
        end
      end
      StWack: state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (!reset_n) cpu_waitrequest = 1'b1;
  end

  // Memory-side outputs are decoded from the state and captured request only.
  always_comb begin
    mem_rd      = reset_n && (state_q == StFill);
    mem_wr      = reset_n && (state_q == StWrite);
    mem_addr    = '0;
    mem_wr_be   = '0;
    mem_wr_data = '0;
    if (state_q == StFill || state_q == StWrite) mem_addr = {addr_q[31:2], 2'b00};
    if (state_q == StWrite) begin
      mem_wr_be   = be_q;
      mem_wr_data = wdata_q;
    end
  end

  // State, counters, request capture and fill response register.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      hit_count_q  <= '0;
      miss_count_q <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      resp_q       <= '0;
    end else begin
      state_q <= state_d;
      if (hit_inc)  hit_count_q  <= hit_count_q + 32'd1;
      if (miss_inc) miss_count_q <= miss_count_q + 32'd1;
      if (capture) begin
        addr_q  <= cpu_addr;
        wdata_q <= cpu_wr_data;
        be_q    <= cpu_wr_be;
      end
      if (fill_en) resp_q <= mem_rd_data;
    end
  end

  // Valid bits: cleared by reset, set by a completed fill.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      valid_q <= '0;
    end else if (fill_en) begin
      valid_q[cap_idx] <= 1'b1;
    end
  end

  // Tag/data storage: written by fills and byte-merged by write hits.
  always_ff @(posedge clock) begin
    if (reset_n && fill_en) begin
      tag_q[cap_idx]  <= cap_tag;
      data_q[cap_idx] <= mem_rd_data;
    end else if (reset_n && merge_en) begin
      for (int b = 0; b < 4; b++) begin
        if (be_q[b]) data_q[cap_idx][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dcache_wt.sv
// Self-checking bench for dcache_wt: directed scenarios plus randomized traffic
// checked against a backing-memory model and a per-index valid/tag model.
module tb_dcache_wt;
  localparam int unsigned LINES = 64;
  localparam int unsigned IDX_W = $clog2(LINES);

  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] cpu_addr, cpu_wr_data, cpu_rd_data;
  logic        cpu_rd, cpu_wr, cpu_waitrequest;
  logic [3:0]  cpu_wr_be, mem_wr_be;
  logic [31:0] mem_addr, mem_wr_data, mem_rd_data;
  logic        mem_rd, mem_wr, mem_waitrequest;
  logic [31:0] hit_count, miss_count;

  dcache_wt #(.LINES(LINES)) dut (
    .clock(clock), .reset_n(reset_n),
    .cpu_addr(cpu_addr), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_wr_be(cpu_wr_be),
    .cpu_wr_data(cpu_wr_data), .cpu_rd_data(cpu_rd_data), .cpu_waitrequest(cpu_waitrequest),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wr_be(mem_wr_be),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data), .mem_waitrequest(mem_waitrequest),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clock = ~clock;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference model: backing memory, and which tag each line holds.
  logic [31:0] mem [logic [31:0]];
  bit          mvalid [LINES];
  logic [31:0] mtag [LINES];
  int unsigned exp_hits, exp_misses;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_get(input logic [31:0] wa);
    if (!mem.exists(wa)) mem[wa] = $urandom;
    return mem[wa];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < LINES; i++) mvalid[i] = 1'b0;
    exp_hits   = 0;
    exp_misses = 0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; cpu_rd = 1'b0; cpu_wr = 1'b0; mem_waitrequest = 1'b0;
    @(negedge clock);
    check_eq("rst_waitreq", {31'd0, cpu_waitrequest}, 32'd1);
    check_eq("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
    check_eq("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(negedge clock);
    check_eq("rst_mem_addr", mem_addr, 32'd0);
    check_eq("rst_mem_be", {28'd0, mem_wr_be}, 32'd0);
    check_eq("rst_mem_wdata", mem_wr_data, 32'd0);
    check_eq("rst_rd_data", cpu_rd_data, 32'd0);
    check_eq("rst_hits", hit_count, 32'd0);
    check_eq("rst_misses", miss_count, 32'd0);
    check_eq("rst_idle_wait", {31'd0, cpu_waitrequest}, 32'd0);
    @(posedge clock); #1;
    model_clear();
  endtask

  // One CPU transaction with the bench acting as memory (wm wait cycles per access).
  task automatic op(input bit rd, input bit wr, input logic [31:0] addr, input logic [3:0] be,
                    input logic [31:0] wd, input int wm,
                    output logic [31:0] rdata, output int lat);
    logic [31:0] wa, exp_data, seen_addr, seen_wdata, mask;
    logic [3:0]  seen_be;
    logic [31:0] tg;
    int          idx, req_cycles, waits;
    bit          is_hit, done, saw_rd, saw_wr;
    wa       = {addr[31:2], 2'b00};
    idx      = int'(addr[IDX_W+1:2]);
    tg       = addr >> (IDX_W + 2);
    is_hit   = mvalid[idx] && (mtag[idx] == tg);
    exp_data = mem_get(wa);
    cpu_addr = addr; cpu_rd = rd; cpu_wr = wr; cpu_wr_be = be; cpu_wr_data = wd;
    lat = 0; req_cycles = 0; waits = wm; done = 0; saw_rd = 0; saw_wr = 0; rdata = '0;
    seen_addr = '0; seen_wdata = '0; seen_be = '0;
    while (!done && lat < 100) begin
      @(negedge clock);
      lat++;
      if (!cpu_waitrequest) begin
        done  = 1;
        rdata = cpu_rd_data;
      end
      if (mem_rd || mem_wr) begin
        if (req_cycles == 0) begin
          seen_addr = mem_addr; seen_be = mem_wr_be; seen_wdata = mem_wr_data;
        end
        saw_rd = saw_rd | mem_rd;
        saw_wr = saw_wr | mem_wr;
        req_cycles++;
        if (waits > 0) begin
          mem_waitrequest = 1'b1; mem_rd_data = $urandom; waits--;
        end else begin
          mem_waitrequest = 1'b0; mem_rd_data = mem_get(wa);
        end
      end else begin
        mem_waitrequest = 1'b0; mem_rd_data = $urandom;
      end
    end
    check_eq("done", {31'd0, done}, 32'd1);
    @(posedge clock); #1;
    cpu_rd = 1'b0; cpu_wr = 1'b0;
    if (wr) begin
      check_eq("wr_latency", lat, 3 + wm);
      check_eq("wr_saw_wr", {31'd0, saw_wr}, 32'd1);
      check_eq("wr_no_rd", {31'd0, saw_rd}, 32'd0);
      check_eq("wr_req_cycles", req_cycles, wm + 1);
      check_eq("wr_mem_addr", seen_addr, wa);
      check_eq("wr_mem_be", {28'd0, seen_be}, {28'd0, be});
      check_eq("wr_mem_data", seen_wdata, wd);
      for (int b = 0; b < 4; b++) mask[8*b +: 8] = be[b] ? 8'hFF : 8'h00;
      mem[wa] = (exp_data & ~mask) | (wd & mask);
    end else if (rd) begin
      check_eq("rd_data", rdata, exp_data);
      if (is_hit) begin
        check_eq("hit_latency", lat, 1);
        check_eq("hit_no_mem", {31'd0, saw_rd | saw_wr}, 32'd0);
        exp_hits++;
      end else begin
        check_eq("miss_latency", lat, 3 + wm);
        check_eq("miss_saw_rd", {31'd0, saw_rd}, 32'd1);
        check_eq("miss_req_cycles", req_cycles, wm + 1);
        check_eq("miss_mem_addr", seen_addr, wa);
        exp_misses++;
        mvalid[idx] = 1'b1;
        mtag[idx]   = tg;
      end
    end
    check_eq("hit_count", hit_count, exp_hits);
    check_eq("miss_count", miss_count, exp_misses);
  endtask

  initial begin
    logic [31:0] rdata, addr;
    int          lat;
    bit          wr, rd;
    int          r;
    reset_n = 1'b0; cpu_addr = '0; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_wr_be = '0;
    cpu_wr_data = '0; mem_rd_data = '0; mem_waitrequest = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    do_reset();

    // Cold miss with two memory wait cycles, then a hit.
    mem[32'h100] = 32'hDEADBEEF;
    op(1, 0, 32'h100, 4'h0, 32'h0, 2, rdata, lat);
    check_eq("tp_miss_lat", lat, 5);
    check_eq("tp_miss_data", rdata, 32'hDEADBEEF);
    check_eq("tp_miss_cnt", miss_count, 32'd1);
    op(1, 0, 32'h100, 4'h0, 32'h0, 0, rdata, lat);
    check_eq("tp_hit_lat", lat, 1);
    check_eq("tp_hit_data", rdata, 32'hDEADBEEF);
    check_eq("tp_hit_cnt", hit_count, 32'd1);

    // Conflict eviction on the same index.
    mem[32'h100 + 4 * LINES] = 32'h12345678;
    op(1, 0, 32'h100 + 4 * LINES, 4'h0, 32'h0, 1, rdata, lat);
    check_eq("tp_evict_data", rdata, 32'h12345678);
    op(1, 0, 32'h100, 4'h0, 32'h0, 0, rdata, lat);
    check_eq("tp_evict_cnt", miss_count, 32'd3);

    // Write hit merges byte 0; write with no enables leaves data alone.
    op(0, 1, 32'h100, 4'b0001, 32'h000000AA, 1, rdata, lat);
    op(1, 0, 32'h100, 4'h0, 32'h0, 0, rdata, lat);
    check_eq("tp_merge_data", rdata, 32'hDEADBEAA);
    op(0, 1, 32'h101, 4'b0000, 32'h55555555, 0, rdata, lat);
    op(1, 0, 32'h100, 4'h0, 32'h0, 0, rdata, lat);
    check_eq("tp_be0_data", rdata, 32'hDEADBEAA);

    // Write miss does not allocate.
    op(0, 1, 32'h1200, 4'hF, 32'hCAFEF00D, 2, rdata, lat);
    op(1, 0, 32'h1200, 4'h0, 32'h0, 0, rdata, lat);
    check_eq("tp_wmiss_data", rdata, 32'hCAFEF00D);

    // Read and write together is a write.
    op(1, 1, 32'h300, 4'hF, 32'h0BADC0DE, 1, rdata, lat);
    check_eq("tp_rdwr_hits", hit_count, exp_hits);

    // Reset in the middle of a fill.
    cpu_addr = 32'h400; cpu_rd = 1'b1; cpu_wr = 1'b0; mem_waitrequest = 1'b1;
    @(posedge clock); #1;
    @(negedge clock);
    check_eq("mf_mem_rd", {31'd0, mem_rd}, 32'd1);
    reset_n = 1'b0;
    #1;
    check_eq("mf_gate_rd", {31'd0, mem_rd}, 32'd0);
    check_eq("mf_gate_wait", {31'd0, cpu_waitrequest}, 32'd1);
    @(posedge clock); #1;
    reset_n = 1'b1; cpu_rd = 1'b0; mem_waitrequest = 1'b0;
    @(negedge clock);
    check_eq("mf_after_rd", {31'd0, mem_rd}, 32'd0);
    check_eq("mf_after_miss", miss_count, 32'd0);
    @(posedge clock); #1;
    model_clear();
    op(1, 0, 32'h100, 4'h0, 32'h0, 1, rdata, lat);
    check_eq("mf_reread_lat", lat, 4);

    // Randomized traffic over a few tags and indices so hits and conflicts both occur.
    for (int n = 0; n < 300; n++) begin
      r    = $urandom_range(0, 9);
      wr   = (r < 3);
      rd   = (r >= 2);
      addr = ($urandom_range(0, 3) << (IDX_W + 2)) | ($urandom_range(0, 7) << 2)
             | $urandom_range(0, 3);
      op(rd, wr, addr, 4'($urandom), $urandom, $urandom_range(0, 3), rdata, lat);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clock); #1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
